// File: rtl/sp_ram_arb_if.sv
// Bus bundle between the two core masters (p0 instruction, p1 data),
// the round-robin arbiter and the single-port RAM wrapper.
interface sp_ram_arb_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  p0_req_i;
    logic                  p0_gnt_o;
    logic [ADDR_WIDTH-1:0] p0_addr_i;
    logic                  p0_we_i;
    logic [3:0]            p0_be_i;
    logic [31:0]           p0_wdata_i;
    logic                  p0_rvalid_o;
    logic [31:0]           p0_rdata_o;

    logic                  p1_req_i;
    logic                  p1_gnt_o;
    logic [ADDR_WIDTH-1:0] p1_addr_i;
    logic                  p1_we_i;
    logic [3:0]            p1_be_i;
    logic [31:0]           p1_wdata_i;
    logic                  p1_rvalid_o;
    logic [31:0]           p1_rdata_o;

    logic                  ram_en_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [31:0]           ram_wdata_o;
    logic                  ram_we_o;
    logic [3:0]            ram_be_o;
    logic [31:0]           ram_rdata_i;

    logic                  init_done_o;

    // Arbiter side
    modport slave (
        input  p0_req_i, p0_addr_i, p0_we_i, p0_be_i, p0_wdata_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        input  p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        output ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o,
        input  ram_rdata_i,
        output init_done_o
    );

    // Master / RAM environment side
    modport master (
        output p0_req_i, p0_addr_i, p0_we_i, p0_be_i, p0_wdata_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        output p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        input  ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o,
        output ram_rdata_i,
        input  init_done_o
    );
endinterface

// File: rtl/sp_ram_arb.sv
// Two-master round-robin arbiter in front of a single-port RAM.
// Optional zero-fill of NUM_WORDS words after reset; OBI-style rvalid
// one cycle after each grant; read data passed straight from the RAM.
module sp_ram_arb #(
    parameter int ADDR_WIDTH = 13,
    parameter int NUM_WORDS  = 8192,
    parameter bit INIT_ZERO  = 1'b1
) (
    input logic         clk,
    input logic         rst_i,
    sp_ram_arb_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  last_gnt;   // 0 = p0 granted last, 1 = p1
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [3:0]            ram_be;
    logic                  init_done;

    // State register; reset lands in INIT or RUN depending on INIT_ZERO
    always_ff @(posedge clk) begin
        if (rst_i) state <= INIT_ZERO ? ST_INIT : ST_RUN;
        else       state <= state_nxt;
    end

    // Zero-fill address counter, advances once per INIT write
    always_ff @(posedge clk) begin
        if (rst_i)                 cnt <= '0;
        else if (state == ST_INIT) cnt <= cnt + 1'b1;
    end

    // Remember the last granted port; reset to p1 so p0 wins first contention
    always_ff @(posedge clk) begin
        if (rst_i)     last_gnt <= 1'b1;
        else if (gnt0) last_gnt <= 1'b0;
        else if (gnt1) last_gnt <= 1'b1;
    end

    // Response valid follows each grant by exactly one cycle
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
        end
    end

    // Next state, grant selection and RAM port mux.
    // Outputs are gated by rst_i so nothing is driven while reset is held,
    // even though the state register only clears on the clock edge.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = bus.p0_addr_i;
        ram_wdata = bus.p0_wdata_i;
        ram_be    = bus.p0_be_i;
        init_done = 1'b0;
        if (!rst_i) begin
            case (state)
                ST_INIT: begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_be    = '1;
                    ram_wdata = '0;
                    ram_addr  = cnt;
                    if (cnt == LAST_ADDR) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    init_done = 1'b1;
                    gnt0 = bus.p0_req_i && (!bus.p1_req_i || last_gnt);
                    gnt1 = bus.p1_req_i && (!bus.p0_req_i || !last_gnt);
                    ram_en = gnt0 || gnt1;
                    if (gnt1) begin
                        ram_addr  = bus.p1_addr_i;
                        ram_wdata = bus.p1_wdata_i;
                        ram_be    = bus.p1_be_i;
                        ram_we    = bus.p1_we_i;
                    end else begin
                        ram_we    = gnt0 && bus.p0_we_i;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    assign bus.p0_gnt_o    = gnt0;
    assign bus.p1_gnt_o    = gnt1;
    assign bus.p0_rvalid_o = rvalid0;
    assign bus.p1_rvalid_o = rvalid1;
    assign bus.p0_rdata_o  = bus.ram_rdata_i;
    assign bus.p1_rdata_o  = bus.ram_rdata_i;
    assign bus.ram_en_o    = ram_en;
    assign bus.ram_we_o    = ram_we;
    assign bus.ram_addr_o  = ram_addr;
    assign bus.ram_wdata_o = ram_wdata;
    assign bus.ram_be_o    = ram_be;
    assign bus.init_done_o = init_done;

endmodule

// File: tb/tb_sp_ram_arb.sv
// Directed bench for sp_ram_arb: one instance with zero-fill, one without,
// each driving a small byte-enabled RAM model with one-cycle read latency.
module tb_sp_ram_arb;

    localparam int AW = 8;
    localparam int NW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic fill_junk;

    sp_ram_arb_if #(.ADDR_WIDTH(AW)) bus_a ();
    sp_ram_arb_if #(.ADDR_WIDTH(AW)) bus_b ();

    sp_ram_arb #(.ADDR_WIDTH(AW), .NUM_WORDS(NW), .INIT_ZERO(1'b1)) dut_a (
        .clk   (clk),
        .rst_i (rst_a),
        .bus   (bus_a)
    );

    sp_ram_arb #(.ADDR_WIDTH(AW), .NUM_WORDS(NW), .INIT_ZERO(1'b0)) dut_b (
        .clk   (clk),
        .rst_i (rst_b),
        .bus   (bus_b)
    );

    // RAM models, preloaded with a non-zero pattern so the zero-fill is visible
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    assign bus_a.ram_rdata_i = rd_a;
    assign bus_b.ram_rdata_i = rd_b;

    always @(posedge clk) begin
        if (fill_junk) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 32'hA5A5_A5A5;
                mem_b[i] <= 32'hA5A5_A5A5;
            end
        end else begin
            if (bus_a.ram_en_o) begin
                if (bus_a.ram_we_o)
                    for (int b = 0; b < 4; b++)
                        if (bus_a.ram_be_o[b])
                            mem_a[bus_a.ram_addr_o][8*b +: 8] <= bus_a.ram_wdata_o[8*b +: 8];
                rd_a <= mem_a[bus_a.ram_addr_o];
            end
            if (bus_b.ram_en_o) begin
                if (bus_b.ram_we_o)
                    for (int b = 0; b < 4; b++)
                        if (bus_b.ram_be_o[b])
                            mem_b[bus_b.ram_addr_o][8*b +: 8] <= bus_b.ram_wdata_o[8*b +: 8];
                rd_b <= mem_b[bus_b.ram_addr_o];
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic init_masters();
        bus_a.p0_req_i = 1'b0; bus_a.p0_addr_i = '0; bus_a.p0_we_i = 1'b0;
        bus_a.p0_be_i = '0;    bus_a.p0_wdata_i = '0;
        bus_a.p1_req_i = 1'b0; bus_a.p1_addr_i = '0; bus_a.p1_we_i = 1'b0;
        bus_a.p1_be_i = '0;    bus_a.p1_wdata_i = '0;
        bus_b.p0_req_i = 1'b0; bus_b.p0_addr_i = '0; bus_b.p0_we_i = 1'b0;
        bus_b.p0_be_i = '0;    bus_b.p0_wdata_i = '0;
        bus_b.p1_req_i = 1'b0; bus_b.p1_addr_i = '0; bus_b.p1_we_i = 1'b0;
        bus_b.p1_be_i = '0;    bus_b.p1_wdata_i = '0;
    endtask

    // Single transaction on dut_a; called just after a rising edge, returns
    // just after a rising edge with the response data captured.
    task automatic acc_a(input int port, input logic we, input logic [AW-1:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         output logic [31:0] rd);
        if (port == 0) begin
            bus_a.p0_req_i = 1'b1; bus_a.p0_we_i = we; bus_a.p0_addr_i = addr;
            bus_a.p0_be_i = be;    bus_a.p0_wdata_i = wd;
        end else begin
            bus_a.p1_req_i = 1'b1; bus_a.p1_we_i = we; bus_a.p1_addr_i = addr;
            bus_a.p1_be_i = be;    bus_a.p1_wdata_i = wd;
        end
        samp();
        check("acc_gnt_sel",   port == 0 ? bus_a.p0_gnt_o : bus_a.p1_gnt_o, 1);
        check("acc_gnt_other", port == 0 ? bus_a.p1_gnt_o : bus_a.p0_gnt_o, 0);
        check("acc_ram_en",    bus_a.ram_en_o, 1);
        check("acc_ram_addr",  bus_a.ram_addr_o, addr);
        check("acc_ram_we",    bus_a.ram_we_o, we);
        check("acc_ram_be",    bus_a.ram_be_o, be);
        if (we) check("acc_ram_wdata", bus_a.ram_wdata_o, wd);
        tick();
        bus_a.p0_req_i = 1'b0;
        bus_a.p1_req_i = 1'b0;
        samp();
        check("acc_rvalid_sel",   port == 0 ? bus_a.p0_rvalid_o : bus_a.p1_rvalid_o, 1);
        check("acc_rvalid_other", port == 0 ? bus_a.p1_rvalid_o : bus_a.p0_rvalid_o, 0);
        rd = (port == 0) ? bus_a.p0_rdata_o : bus_a.p1_rdata_o;
        tick();
    endtask

    logic [31:0] rd;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        fill_junk = 1'b1;
        init_masters();
        tick();
        fill_junk = 1'b0;
        tick();
        samp();
        // Reset state
        check("rst_a_en",     bus_a.ram_en_o, 0);
        check("rst_a_we",     bus_a.ram_we_o, 0);
        check("rst_a_gnt0",   bus_a.p0_gnt_o, 0);
        check("rst_a_gnt1",   bus_a.p1_gnt_o, 0);
        check("rst_a_rv0",    bus_a.p0_rvalid_o, 0);
        check("rst_a_rv1",    bus_a.p1_rvalid_o, 0);
        check("rst_a_done",   bus_a.init_done_o, 0);
        check("rst_b_en",     bus_b.ram_en_o, 0);
        check("rst_b_done",   bus_b.init_done_o, 0);

        // No zero-fill: RUN immediately, p1 read granted in first cycle
        tick();
        rst_b = 1'b0;
        bus_b.p1_req_i = 1'b1; bus_b.p1_addr_i = 8'd7; bus_b.p1_we_i = 1'b0; bus_b.p1_be_i = 4'hF;
        samp();
        check("b_done",  bus_b.init_done_o, 1);
        check("b_gnt1",  bus_b.p1_gnt_o, 1);
        check("b_gnt0",  bus_b.p0_gnt_o, 0);
        check("b_en",    bus_b.ram_en_o, 1);
        check("b_we",    bus_b.ram_we_o, 0);
        check("b_addr",  bus_b.ram_addr_o, 7);
        tick();
        bus_b.p1_req_i = 1'b0;
        samp();
        check("b_rv1",   bus_b.p1_rvalid_o, 1);
        check("b_rdata", bus_b.p1_rdata_o, 32'hA5A5_A5A5);

        // Zero-fill, with a p0 read of addr 5 pending throughout
        tick();
        rst_a = 1'b0;
        bus_a.p0_req_i = 1'b1; bus_a.p0_addr_i = 8'd5; bus_a.p0_we_i = 1'b0; bus_a.p0_be_i = 4'hF;
        for (int i = 0; i < NW; i++) begin
            samp();
            check("init_en",    bus_a.ram_en_o, 1);
            check("init_we",    bus_a.ram_we_o, 1);
            check("init_addr",  bus_a.ram_addr_o, i);
            check("init_be",    bus_a.ram_be_o, 4'hF);
            check("init_wdata", bus_a.ram_wdata_o, 0);
            check("init_gnt0",  bus_a.p0_gnt_o, 0);
            check("init_rv0",   bus_a.p0_rvalid_o, 0);
            check("init_done",  bus_a.init_done_o, 0);
            tick();
        end
        samp();
        check("run_done",      bus_a.init_done_o, 1);
        check("run_gnt0",      bus_a.p0_gnt_o, 1);
        check("run_addr",      bus_a.ram_addr_o, 5);
        check("run_we",        bus_a.ram_we_o, 0);
        tick();
        bus_a.p0_req_i = 1'b0;
        samp();
        check("run_rv0",       bus_a.p0_rvalid_o, 1);
        check("run_rdata0",    bus_a.p0_rdata_o, 0);
        tick();

        // Full-word write then read back on p0
        acc_a(0, 1'b1, 8'h10, 4'hF, 32'hDEAD_BEEF, rd);
        acc_a(0, 1'b0, 8'h10, 4'hF, 32'h0, rd);
        check("rd_10", rd, 32'hDEAD_BEEF);

        // Partial byte-enable write on p1
        acc_a(1, 1'b1, 8'h03, 4'hF, 32'h1122_3344, rd);
        acc_a(1, 1'b1, 8'h03, 4'b0101, 32'hAABB_CCDD, rd);
        acc_a(1, 0, 8'h03, 4'hF, 32'h0, rd);
        check("rd_03_be", rd, 32'h11BB_33DD);

        // Continuous contention: last grant was p1, so p0 goes first
        bus_a.p0_req_i = 1'b1; bus_a.p0_we_i = 1'b0; bus_a.p0_addr_i = 8'h10; bus_a.p0_be_i = 4'hF;
        bus_a.p1_req_i = 1'b1; bus_a.p1_we_i = 1'b0; bus_a.p1_addr_i = 8'h03; bus_a.p1_be_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            samp();
            check("rr_gnt0", bus_a.p0_gnt_o, (i % 2) == 0);
            check("rr_gnt1", bus_a.p1_gnt_o, (i % 2) == 1);
            check("rr_both", bus_a.p0_gnt_o & bus_a.p1_gnt_o, 0);
            check("rr_addr", bus_a.ram_addr_o, ((i % 2) == 0) ? 8'h10 : 8'h03);
            if (i > 0) begin
                check("rr_rv0", bus_a.p0_rvalid_o, ((i - 1) % 2) == 0);
                check("rr_rv1", bus_a.p1_rvalid_o, ((i - 1) % 2) == 1);
                check("rr_rdata", bus_a.p0_rdata_o,
                      (((i - 1) % 2) == 0) ? 32'hDEAD_BEEF : 32'h11BB_33DD);
            end
            tick();
        end
        bus_a.p0_req_i = 1'b0;
        bus_a.p1_req_i = 1'b0;
        samp();
        check("rr_last_rv1",   bus_a.p1_rvalid_o, 1);
        check("rr_last_rv0",   bus_a.p0_rvalid_o, 0);
        check("rr_last_rdata", bus_a.p1_rdata_o, 32'h11BB_33DD);
        tick();

        // Reset with a response pending drops it
        bus_a.p0_req_i = 1'b1; bus_a.p0_addr_i = 8'h10; bus_a.p0_we_i = 1'b0;
        samp();
        check("pend_gnt0", bus_a.p0_gnt_o, 1);
        rst_a = 1'b1;
        tick();
        bus_a.p0_req_i = 1'b0;
        samp();
        check("pend_rv0",  bus_a.p0_rvalid_o, 0);
        check("pend_en",   bus_a.ram_en_o, 0);
        check("pend_done", bus_a.init_done_o, 0);
        tick();
        rst_a = 1'b0;

        // Reset in the middle of the fill restarts it from address 0
        for (int i = 0; i < 10; i++) begin
            samp();
            check("fill1_addr", bus_a.ram_addr_o, i);
            if (i < 9) tick();
        end
        rst_a = 1'b1;
        #1;
        check("mid_rst_en", bus_a.ram_en_o, 0);
        tick();
        rst_a = 1'b0;
        for (int i = 0; i < NW; i++) begin
            samp();
            check("fill2_addr", bus_a.ram_addr_o, i);
            check("fill2_we",   bus_a.ram_we_o, 1);
            check("fill2_done", bus_a.init_done_o, 0);
            tick();
        end
        samp();
        check("fill2_run", bus_a.init_done_o, 1);
        check("fill2_idle_en", bus_a.ram_en_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sp_ram_arb.md
Name: sp_ram_arb

Overview:
Two-master request/grant front end that sits directly upstream of the single-port RAM wrapper and drives its en/addr/wdata/we/be inputs.
- Arbitrates the core instruction port (p0) and data port (p1) round-robin onto the one RAM port.
- Returns read data with OBI-style rvalid.
- Optionally zero-fills the whole RAM after reset before accepting any traffic.

Parameters:
ADDR_WIDTH, 13, word-address width on both master and RAM sides.
NUM_WORDS, 8192, number of words zero-filled during init; must be <= 2**ADDR_WIDTH.
INIT_ZERO, 1, 1 = run the zero-fill sequence after reset; 0 = enter RUN directly.

Ports:
clk  in  1  clock
rst_i  in  1  synchronous reset, active-high
p0_req_i  in  1  master 0 request
p0_gnt_o  out  1  master 0 grant (combinational)
p0_addr_i  in  ADDR_WIDTH  master 0 word address
p0_we_i  in  1  master 0 write enable
p0_be_i  in  4  master 0 byte enables
p0_wdata_i  in  32  master 0 write data
p0_rvalid_o  out  1  master 0 response valid
p0_rdata_o  out  32  master 0 read data
p1_*  same set as p0_*, for master 1
ram_en_o  out  1  RAM enable
ram_addr_o  out  ADDR_WIDTH  RAM address
ram_wdata_o  out  32  RAM write data
ram_we_o  out  1  RAM write enable
ram_be_o  out  4  RAM byte enables
ram_rdata_i  in  32  RAM read data, valid one cycle after ram_en_o
init_done_o  out  1  high once in RUN

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high (rst_i); all registers update only on the rising edge of clk.
- While rst_i is high: ram_en_o=0, ram_we_o=0, both gnt=0, both rvalid=0, init_done_o=0, init counter=0, last_gnt=1 (so p0 wins the first contention).
- After reset the FSM is in INIT if INIT_ZERO=1, otherwise in RUN.
- INIT state:
  - Each cycle drive ram_en_o=1, ram_we_o=1, ram_be_o=4'hF, ram_wdata_o=0, ram_addr_o=counter.
  - Counter increments each cycle. After the write to NUM_WORDS-1, go to RUN: exactly NUM_WORDS write cycles.
  - Grants are 0 and requests are ignored (they stay pending).
  - rst_i mid-INIT restarts at counter 0.
- RUN state:
  - init_done_o=1.
  - Selection:
    - Only p0 requests: grant p0.
    - Only p1 requests: grant p1.
    - Both request: grant the port not equal to last_gnt.
  - last_gnt updates to the granted port on every grant.
  - The granted port's gnt_o=1 in the same cycle as req. RAM outputs mux combinationally from the granted port's addr/we/be/wdata, with ram_en_o=1.
  - No request: ram_en_o=0, ram_we_o=0; other RAM outputs are don't-care but held at the p0 values.
- Response path:
  - rvalid is registered. The granted port's rvalid_o=1 exactly one cycle after its grant, for reads and writes alike.
  - pX_rdata_o = ram_rdata_i combinationally. Contents are meaningful only for read responses; 0 is not required.
  - Back-to-back grants give back-to-back rvalids.
  - A response is never lost or reordered; there is no rvalid back-pressure.
- Each master holds its request fields stable until gnt; the arbiter does not register them.
- Throughput: one access per cycle. Worst-case wait for a continuously requesting master is 1 cycle.
- No combinational path from rvalid to gnt.
- The arbiter never asserts both grants in one cycle.

Test Plan:
1. INIT_ZERO=1, NUM_WORDS=16, release rst_i -> exactly 16 cycles of ram_we_o=1 with addr 0..15, be=F, wdata=0. init_done_o rises the cycle after addr 15. A p0 read of addr 5 issued during INIT is granted only after that and returns 0.
2. RUN, p0 write addr 0x10 data 0xDEADBEEF be=F, then read 0x10 -> gnt in the request cycle, rvalid 1 cycle later for each, read data 0xDEADBEEF.
3. Write 0x11223344 to addr 3, then write 0xAABBCCDD be=4'b0101, then read -> 0x11BB33DD; ram_be_o matches each request.
4. p0 and p1 both request continuously for 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1. Each rvalid appears on the matching port one cycle later; never two gnts in one cycle.
5. Assert rst_i for 1 cycle while the INIT counter is at 9 -> fill restarts at addr 0 and takes a full NUM_WORDS cycles. Any rvalid pending at reset is dropped (rvalid=0 the next cycle).
6. INIT_ZERO=0 -> init_done_o=1 the first cycle after reset, no RAM writes; a p1 read in that cycle is granted immediately.
